issue_scoreboard: RTL and testbench

Single-entry issue stage between the decode register and the execution units (ALU, load/store unit). It holds one decoded instruction, tracks pending register writes in a 32-entry busy scoreboard, and releases the instruction to the ALU or LSU port only when its source and destination registers are free and the target unit can accept it. Back-pressure to decode is the `in_ready` handshake; completions from both units clear scoreboard entries.

---
 rtl/issue_scoreboard.sv | 192 +++++++++++++++++++
 tb/tb_issue_scoreboard.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_scoreboard
//
// Purpose:
//   A single-entry issue stage that sits between the decode register and the
//   execution units (ALU and load/store unit). It holds one decoded
//   instruction and tracks pending register writes in a 32-entry busy
//   scoreboard. The held instruction is released to its target unit only when
//   its source and destination registers are free and that unit can take it.
//   Completions from either unit clear busy bits. A completion can release a
//   dependent instruction in the same cycle it arrives.
//
// Ports:
//   clk, reset_n                  clock; asynchronous active-low reset
//   flush                         discard the held instruction (synchronous)
//   in_valid / in_ready           decode handshake
//   in_rd, in_rs1, in_rs2         register indices; unused sources arrive as 0
//   in_regwrite, in_loadstore     writes rd / route to LSU (1) or ALU (0)
//   in_payload                    opaque decoded fields, passed through as-is
//   alu_issue_valid / _ready      ALU issue handshake
//   lsu_issue_valid / _ready      LSU issue handshake
//   issue_rd, issue_regwrite,
//   issue_payload                 held instruction fields, shared by both ports
//   alu_done, alu_done_rd         ALU completion
//   lsu_done, lsu_done_rd         LSU completion (every op; rd=0 for stores)
//   busy_vec                      scoreboard; bit 0 is always 0
//   stall_cycles                  saturating count of held-but-blocked cycles
// -----------------------------------------------------------------------------
module issue_scoreboard #(
  parameter int PAYLOAD_W   = 64,
  parameter int LSU_MAX_OUT = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic                 in_regwrite,
  input  logic                 in_loadstore,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 alu_issue_valid,
  input  logic                 alu_issue_ready,
  output logic                 lsu_issue_valid,
  input  logic                 lsu_issue_ready,
  output logic [4:0]           issue_rd,
  output logic                 issue_regwrite,
  output logic [PAYLOAD_W-1:0] issue_payload,
  input  logic                 alu_done,
  input  logic [4:0]           alu_done_rd,
  input  logic                 lsu_done,
  input  logic [4:0]           lsu_done_rd,
  output logic [31:0]          busy_vec,
  output logic [15:0]          stall_cycles
);

  typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_t;

  localparam logic [2:0] LSU_MAX = 3'(LSU_MAX_OUT);

  state_t               state_reg, state_next;
  logic [4:0]           rd_reg, rs1_reg, rs2_reg;
  logic                 regwrite_reg, loadstore_reg;
  logic [PAYLOAD_W-1:0] payload_reg;
  logic [31:0]          busy_reg, busy_next;
  logic [2:0]           lsu_out_reg, lsu_out_next;
  logic [15:0]          stall_reg, stall_next;

  logic [31:0] done_clr;   // bits named by this cycle's completions
  logic [31:0] set_mask;   // bit set by this cycle's fire
  logic [31:0] eff_busy;   // scoreboard with same-cycle completions bypassed
  logic        clear;
  logic        lsu_dec;
  logic [2:0]  lsu_out_eff;
  logic        alu_fire, lsu_fire, fire, accept;

  // Completion and set decoders, one per scoreboard entry.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_sb
      assign done_clr[gi] = (alu_done && (alu_done_rd == 5'(gi))) ||
                            (lsu_done && (lsu_done_rd == 5'(gi)));
      if (gi == 0) begin : g_zero
        // x0 is never a real destination, so it never becomes busy.
        assign set_mask[gi] = 1'b0;
      end else begin : g_set
        assign set_mask[gi] = fire && regwrite_reg && (rd_reg == 5'(gi));
      end
    end
  endgenerate

  assign eff_busy = busy_reg & ~done_clr;

  // RAW on both sources, plus WAW on the destination. The WAW check keeps
  // two writes to the same register from being outstanding at once.
  assign clear = ~eff_busy[rs1_reg] & ~eff_busy[rs2_reg] &
                 ~(regwrite_reg & eff_busy[rd_reg]);

  // An LSU completion in this cycle frees a slot right away, in the same way
  // a completion bypasses the busy bits. A completion with nothing
  // outstanding is ignored.
  assign lsu_dec     = lsu_done & (lsu_out_reg != 3'd0);
  assign lsu_out_eff = lsu_out_reg - {2'b00, lsu_dec};

  // Next-state logic and handshake outputs. The valids are computed before
  // fire; neither valid depends on a ready input.
  always_comb begin
    state_next      = state_reg;
    alu_issue_valid = 1'b0;
    lsu_issue_valid = 1'b0;
    alu_fire        = 1'b0;
    lsu_fire        = 1'b0;
    fire            = 1'b0;
    in_ready        = 1'b0;
    accept          = 1'b0;

    if (state_reg == HELD && !flush && clear) begin
      alu_issue_valid = ~loadstore_reg;
      lsu_issue_valid = loadstore_reg & (lsu_out_eff < LSU_MAX);
    end
    alu_fire = alu_issue_valid & alu_issue_ready;
    lsu_fire = lsu_issue_valid & lsu_issue_ready;
    fire     = alu_fire | lsu_fire;
    in_ready = ~flush & ((state_reg == EMPTY) | fire);
    accept   = in_valid & in_ready;

    if (flush)       state_next = EMPTY;
    else if (accept) state_next = HELD;
    else if (fire)   state_next = EMPTY;
  end

  // When a bit is set and cleared on the same edge, the set wins. A new
  // write to rd must stay pending even if an older write to rd completes.
  assign busy_next = eff_busy | set_mask;

  always_comb begin
    lsu_out_next = lsu_out_reg;
    case ({lsu_fire, lsu_dec})
      2'b10:   lsu_out_next = lsu_out_reg + 3'd1;
      2'b01:   lsu_out_next = lsu_out_reg - 3'd1;
      default: lsu_out_next = lsu_out_reg;
    endcase
  end

  always_comb begin
    stall_next = stall_reg;
    if (state_reg == HELD && !fire && !flush && stall_reg != 16'hFFFF)
      stall_next = stall_reg + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_reg        <= '0;
      rs1_reg       <= '0;
      rs2_reg       <= '0;
      regwrite_reg  <= 1'b0;
      loadstore_reg <= 1'b0;
      payload_reg   <= '0;
      busy_reg      <= '0;
      lsu_out_reg   <= '0;
      stall_reg     <= '0;
    end else begin
      if (accept) begin
        rd_reg        <= in_rd;
        rs1_reg       <= in_rs1;
        rs2_reg       <= in_rs2;
        regwrite_reg  <= in_regwrite;
        loadstore_reg <= in_loadstore;
        payload_reg   <= in_payload;
      end
      busy_reg    <= busy_next;
      lsu_out_reg <= lsu_out_next;
      stall_reg   <= stall_next;
    end
  end

  assign issue_rd       = rd_reg;
  assign issue_regwrite = regwrite_reg;
  assign issue_payload  = payload_reg;
  assign busy_vec       = busy_reg;
  assign stall_cycles   = stall_reg;

endmodule

// File: tb/tb_issue_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_issue_scoreboard
//
// Directed testbench for issue_scoreboard. Each scenario has its own task.
// The task drives the stimulus and compares outputs against hand-computed
// values. Inputs are driven 1 time unit after the rising edge. Outputs are
// sampled after they settle, well away from the next rising edge.
// -----------------------------------------------------------------------------
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic        in_regwrite, in_loadstore;
  logic [63:0] in_payload;
  logic        alu_issue_valid, alu_issue_ready;
  logic        lsu_issue_valid, lsu_issue_ready;
  logic [4:0]  issue_rd;
  logic        issue_regwrite;
  logic [63:0] issue_payload;
  logic        alu_done, lsu_done;
  logic [4:0]  alu_done_rd, lsu_done_rd;
  logic [31:0] busy_vec;
  logic [15:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  issue_scoreboard #(.PAYLOAD_W(64), .LSU_MAX_OUT(2)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_regwrite(in_regwrite), .in_loadstore(in_loadstore), .in_payload(in_payload),
    .alu_issue_valid(alu_issue_valid), .alu_issue_ready(alu_issue_ready),
    .lsu_issue_valid(lsu_issue_valid), .lsu_issue_ready(lsu_issue_ready),
    .issue_rd(issue_rd), .issue_regwrite(issue_regwrite), .issue_payload(issue_payload),
    .alu_done(alu_done), .alu_done_rd(alu_done_rd),
    .lsu_done(lsu_done), .lsu_done_rd(lsu_done_rd),
    .busy_vec(busy_vec), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; in_valid = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0;
    in_regwrite = 0; in_loadstore = 0; in_payload = 0;
    alu_issue_ready = 0; lsu_issue_ready = 0;
    alu_done = 0; alu_done_rd = 0; lsu_done = 0; lsu_done_rd = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 0;
    tick();
    reset_n = 1;
  endtask

  task automatic drive_in(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic rw, input logic ls, input logic [63:0] pl);
    in_valid = 1; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_regwrite = rw; in_loadstore = ls; in_payload = pl;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 0;
    tick(); tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
    total++; if (alu_issue_valid !== 1'b0) begin bad++; $display("FAIL rst_alu_valid got=%0b exp=0", alu_issue_valid); end
    total++; if (lsu_issue_valid !== 1'b0) begin bad++; $display("FAIL rst_lsu_valid got=%0b exp=0", lsu_issue_valid); end
    total++; if (issue_rd !== 5'd0) begin bad++; $display("FAIL rst_issue_rd got=%0d exp=0", issue_rd); end
    total++; if (issue_regwrite !== 1'b0) begin bad++; $display("FAIL rst_issue_regwrite got=%0b exp=0", issue_regwrite); end
    total++; if (issue_payload !== 64'd0) begin bad++; $display("FAIL rst_issue_payload got=%0h exp=0", issue_payload); end
    total++; if (busy_vec !== 32'd0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", busy_vec); end
    total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL rst_stall got=%0d exp=0", stall_cycles); end
    reset_n = 1;
    alu_issue_ready = 1;
    drive_in(5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 64'h3);
    tick();
    drive_in(5'd5, 5'd1, 5'd2, 1'b1, 1'b0, 64'hAA);
    tick();
    in_valid = 0; alu_issue_ready = 0;
    #1;
    total++; if (busy_vec !== 32'h8) begin bad++; $display("FAIL rstheld_busy got=%0h exp=8", busy_vec); end
    total++; if (alu_issue_valid !== 1'b1) begin bad++; $display("FAIL rstheld_alu_valid got=%0b exp=1", alu_issue_valid); end
    total++; if (issue_payload !== 64'hAA) begin bad++; $display("FAIL rstheld_payload got=%0h exp=aa", issue_payload); end
    tick();
    total++; if (stall_cycles !== 16'd1) begin bad++; $display("FAIL rstheld_stall got=%0d exp=1", stall_cycles); end
    reset_n = 0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%0b exp=1", in_ready); end
    total++; if (alu_issue_valid !== 1'b0) begin bad++; $display("FAIL midrst_alu_valid got=%0b exp=0", alu_issue_valid); end
    total++; if (issue_rd !== 5'd0) begin bad++; $display("FAIL midrst_issue_rd got=%0d exp=0", issue_rd); end
    total++; if (issue_regwrite !== 1'b0) begin bad++; $display("FAIL midrst_regwrite got=%0b exp=0", issue_regwrite); end
    total++; if (issue_payload !== 64'd0) begin bad++; $display("FAIL midrst_payload got=%0h exp=0", issue_payload); end
    total++; if (busy_vec !== 32'd0) begin bad++; $display("FAIL midrst_busy got=%0h exp=0", busy_vec); end
    total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL midrst_stall got=%0d exp=0", stall_cycles); end
    tick();
    reset_n = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL postrst_in_ready got=%0b exp=1", in_ready); end
    $display("test_reset done: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_back_to_back();
    do_reset();
    alu_issue_ready = 1;
    drive_in(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 64'h11);
    tick();
    drive_in(5'd4, 5'd6, 5'd7, 1'b1, 1'b0, 64'h44);
    #1;
    total++; if (alu_issue_valid !== 1'b1) begin bad++; $display("FAIL b2b_add_valid got=%0b exp=1", alu_issue_valid); end
    total++; if (issue_rd !== 5'd1) begin bad++; $display("FAIL b2b_add_rd got=%0d exp=1", issue_rd); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%0b exp=1", in_ready); end
    tick();
    in_valid = 0;
    #1;
    total++; if (alu_issue_valid !== 1'b1) begin bad++; $display("FAIL b2b_xor_valid got=%0b exp=1", alu_issue_valid); end
    total++; if (issue_rd !== 5'd4) begin bad++; $display("FAIL b2b_xor_rd got=%0d exp=4", issue_rd); end
    total++; if (busy_vec !== 32'h2) begin bad++; $display("FAIL b2b_busy_mid got=%0h exp=2", busy_vec); end
    tick();
    total++; if (alu_issue_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%0b exp=0", alu_issue_valid); end
    total++; if (busy_vec !== 32'h12) begin bad++; $display("FAIL b2b_busy got=%0h exp=12", busy_vec); end
    total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL b2b_stall got=%0d exp=0", stall_cycles); end
    $display("test_back_to_back done: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_raw_bypass();
    do_reset();
    alu_issue_ready = 1;
    drive_in(5'd5, 5'd1, 5'd2, 1'b1, 1'b0, 64'h5);
    tick();
    drive_in(5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 64'h6);
    tick();
    in_valid = 0;
    #1;
    total++; if (alu_issue_valid !== 1'b0) begin bad++; $display("FAIL raw_blocked got=%0b exp=0", alu_issue_valid); end
    total++; if (issue_rd !== 5'd6) begin bad++; $display("FAIL raw_rd got=%0d exp=6", issue_rd); end
    tick(); tick(); tick();
    total++; if (stall_cycles !== 16'd3) begin bad++; $display("FAIL raw_stall_pre got=%0d exp=3", stall_cycles); end
    alu_done = 1; alu_done_rd = 5'd5;
    #1;
    total++; if (alu_issue_valid !== 1'b1) begin bad++; $display("FAIL raw_bypass_valid got=%0b exp=1", alu_issue_valid); end
    total++; if (busy_vec !== 32'h20) begin bad++; $display("FAIL raw_busy_same got=%0h exp=20", busy_vec); end
    tick();
    alu_done = 0;
    #1;
    total++; if (busy_vec !== 32'h40) begin bad++; $display("FAIL raw_busy_after got=%0h exp=40", busy_vec); end
    total++; if (stall_cycles !== 16'd3) begin bad++; $display("FAIL raw_stall got=%0d exp=3", stall_cycles); end
    total++; if (alu_issue_valid !== 1'b0) begin bad++; $display("FAIL raw_empty got=%0b exp=0", alu_issue_valid); end
    $display("test_raw_bypass done: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_lsu_limit();
    do_reset();
    lsu_issue_ready = 1;
    drive_in(5'd8, 5'd1, 5'd0, 1'b1, 1'b1, 64'h8);
    tick();
    drive_in(5'd9, 5'd1, 5'd0, 1'b1, 1'b1, 64'h9);
    tick();
    drive_in(5'd10, 5'd1, 5'd0, 1'b1, 1'b1, 64'hA);
    tick();
    in_valid = 0;
    #1;
    total++; if (lsu_issue_valid !== 1'b0) begin bad++; $display("FAIL lsu_third_held got=%0b exp=0", lsu_issue_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL lsu_in_ready got=%0b exp=0", in_ready); end
    total++; if (issue_rd !== 5'd10) begin bad++; $display("FAIL lsu_rd got=%0d exp=10", issue_rd); end
    tick();
    lsu_done = 1; lsu_done_rd = 5'd8;
    #1;
    total++; if (lsu_issue_valid !== 1'b1) begin bad++; $display("FAIL lsu_done_release got=%0b exp=1", lsu_issue_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lsu_fire_ready got=%0b exp=1", in_ready); end
    tick();
    lsu_done = 0;
    #1;
    total++; if (busy_vec !== 32'h600) begin bad++; $display("FAIL lsu_busy got=%0h exp=600", busy_vec); end
    total++; if (stall_cycles !== 16'd1) begin bad++; $display("FAIL lsu_stall got=%0d exp=1", stall_cycles); end
    drive_in(5'd11, 5'd1, 5'd0, 1'b1, 1'b1, 64'hB);
    tick();
    in_valid = 0;
    #1;
    total++; if (lsu_issue_valid !== 1'b0) begin bad++; $display("FAIL lsu_out_still2 got=%0b exp=0", lsu_issue_valid); end
    lsu_done = 1; lsu_done_rd = 5'd9;
    #1;
    total++; if (lsu_issue_valid !== 1'b1) begin bad++; $display("FAIL lsu_fourth_release got=%0b exp=1", lsu_issue_valid); end
    tick();
    lsu_done = 0;
    $display("test_lsu_limit done: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_waw();
    do_reset();
    alu_issue_ready = 1;
    drive_in(5'd5, 5'd1, 5'd2, 1'b1, 1'b0, 64'h5);
    tick();
    drive_in(5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 64'h55);
    tick();
    in_valid = 0;
    #1;
    total++; if (alu_issue_valid !== 1'b0) begin bad++; $display("FAIL waw_blocked got=%0b exp=0", alu_issue_valid); end
    tick();
    alu_done = 1; alu_done_rd = 5'd5;
    #1;
    total++; if (alu_issue_valid !== 1'b1) begin bad++; $display("FAIL waw_release got=%0b exp=1", alu_issue_valid); end
    tick();
    alu_done = 0;
    #1;
    total++; if (busy_vec !== 32'h20) begin bad++; $display("FAIL waw_set_wins got=%0h exp=20", busy_vec); end
    total++; if (stall_cycles !== 16'd1) begin bad++; $display("FAIL waw_stall got=%0d exp=1", stall_cycles); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL waw_in_ready got=%0b exp=1", in_ready); end
    $display("test_waw done: total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_flush_store();
    do_reset();
    alu_issue_ready = 1;
    drive_in(5'd5, 5'd1, 5'd2, 1'b1, 1'b0, 64'h5);
    tick();
    drive_in(5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 64'h6);
    tick();
    // Offer an independent instruction during the flush; it must not be taken.
    drive_in(5'd7, 5'd1, 5'd2, 1'b1, 1'b0, 64'h7);
    flush = 1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%0b exp=0", in_ready); end
    total++; if (alu_issue_valid !== 1'b0) begin bad++; $display("FAIL flush_alu_valid got=%0b exp=0", alu_issue_valid); end
    tick();
    flush = 0; in_valid = 0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL postflush_in_ready got=%0b exp=1", in_ready); end
    total++; if (alu_issue_valid !== 1'b0) begin bad++; $display("FAIL postflush_empty got=%0b exp=0", alu_issue_valid); end
    total++; if (busy_vec !== 32'h20) begin bad++; $display("FAIL postflush_busy got=%0h exp=20", busy_vec); end
    total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL postflush_stall got=%0d exp=0", stall_cycles); end
    lsu_issue_ready = 1;
    drive_in(5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 64'h5E);
    tick();
    in_valid = 0;
    #1;
    total++; if (lsu_issue_valid !== 1'b1) begin bad++; $display("FAIL sw_valid got=%0b exp=1", lsu_issue_valid); end
    tick();
    lsu_done = 1; lsu_done_rd = 5'd0;
    tick();
    lsu_done = 0;
    #1;
    total++; if (busy_vec !== 32'h20) begin bad++; $display("FAIL sw_busy got=%0h exp=20", busy_vec); end
    // With lsu_out back at 0, two more stores can issue back to back.
    drive_in(5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 64'h51);
    tick();
    drive_in(5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 64'h52);
    tick();
    in_valid = 0;
    #1;
    total++; if (lsu_issue_valid !== 1'b1) begin bad++; $display("FAIL sw_out_zero got=%0b exp=1", lsu_issue_valid); end
    total++; if (issue_payload !== 64'h52) begin bad++; $display("FAIL sw_payload got=%0h exp=52", issue_payload); end
    tick();
    $display("test_flush_store done: total=%0d bad=%0d", total, bad);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_raw_bypass();
    test_lsu_limit();
    test_waw();
    test_flush_store();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
